ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
- Shares one single-read/single-write scratch RAM between NUM_RD read clients and NUM_WR write clients.
- Per-port round-robin arbitration with a same-cycle req/gnt handshake; drives the RAM request ports directly.
- Tracks the fixed 2-cycle RAM read latency and returns read data tagged with the requesting client ID.
- Sits between the conv engine's buffer fetch/store units and the RAM instance.

Parameters:
- NUM_RD, 4, number of read clients (>=1).
- NUM_WR, 2, number of write clients (>=1).
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 16, RAM address width.
- RD_ID_W, clog2(NUM_RD) (min 1), width of the returned read client ID.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; the top level feeds its inverse to the RAM's active-high reset.
- rd_req  in  NUM_RD  per-client read request; held until granted.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed per-client read address; client i in slice i.
- rd_gnt  out  NUM_RD  one-hot combinational grant; the transfer happens when rd_req[i] & rd_gnt[i].
- wr_req  in  NUM_WR  per-client write request; held until granted.
- wr_addr  in  NUM_WR*ADDR_WIDTH  packed write addresses.
- wr_data  in  NUM_WR*DATA_WIDTH  packed write data.
- wr_gnt  out  NUM_WR  one-hot combinational write grant.
- rd_resp_valid  out  1  registered; read data valid this cycle.
- rd_resp_id  out  RD_ID_W  registered; client index for rd_resp_data.
- rd_resp_data  out  DATA_WIDTH  driven directly from ram_read_data.
- ram_read_req  out  1  to RAM s_read_req.
- ram_read_addr  out  ADDR_WIDTH  to RAM s_read_addr.
- ram_read_data  in  DATA_WIDTH  from RAM s_read_data.
- ram_write_req  out  1  to RAM s_write_req.
- ram_write_addr  out  ADDR_WIDTH  to RAM s_write_addr.
- ram_write_data  out  DATA_WIDTH  to RAM s_write_data.

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - Both round-robin pointers go to client 0.
  - The response pipeline is cleared and rd_resp_valid=0, rd_resp_id=0.
  - Grant and RAM request outputs are combinational and therefore 0 while all req are 0.
  - Reset in mid-operation discards in-flight reads; no response is ever emitted for them.
- Arbitration:
  - Read and write arbiters are independent round-robin.
  - Highest priority goes to the client after the last granted one, with wrap from N-1 to 0.
  - The pointer advances only on an actual grant.
  - With no requests, the grant is 0 and the pointer holds.
- RAM drive:
  - ram_read_req = |rd_gnt; ram_read_addr is the granted client's address (0 when idle).
  - The write side works the same way.
  - At most one read and one write per cycle.
- Read latency:
  - A read granted in cycle t has ram_read_data valid in cycle t+2.
  - The arbiter carries valid+ID through a 2-stage shift register, so rd_resp_valid/rd_resp_id assert in cycle t+2, aligned with ram_read_data.
  - Back-to-back grants give one response per cycle, in grant order.
- Same-address hazard:
  - The RAM commits a write 2 edges after request. A read requested in the same cycle to the same address would return old data.
  - Rule: if the read winner's address equals the write winner's address in the same cycle, suppress the read grant.
  - In that case the write proceeds, the read pointer does not advance, and the same read client wins next cycle and sees the new data.
  - A read one or more cycles after the write needs no stall.
- Clients must keep req/addr/data stable until granted. A request dropped before its grant is legal and simply never issues.

Decomposition:
- Package ram_arb_pkg:
  - RAM_RD_LATENCY=2.
  - clog2 function.
  - Index-slicing helper macros/functions for packed client buses.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports: req[N], advance, gnt[N] one-hot.
  - Holds the priority pointer.
  - Instantiated once for reads and once for writes.

Test Plan:
1. Single read: rd_req[2]=1, addr 0x0010, RAM preloaded 0xBEEF -> rd_gnt=0100 same cycle, ram_read_addr=0x0010; 2 cycles later rd_resp_valid=1, id=2, data=0xBEEF.
2. Fairness: all 4 read clients request continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses with IDs in that order, one per cycle starting cycle 2.
3. Write then read: write client 1 writes 0x1234 to 0x0020 in cycle t, read client 0 reads 0x0020 in t+1 -> response in t+3 = 0x1234.
4. Hazard: in the same cycle, write 0x5A5A to 0x0030 and read 0x0030 -> rd_gnt=0 and wr_gnt granted that cycle; read granted next cycle; response = 0x5A5A. A different-address read in the same cycle is granted with no stall.
5. Idle and pointer hold: read client 3 granted, then no requests for 5 cycles, then clients 0 and 3 request -> client 0 granted first (pointer at 0 after wrap from 3).
6. Reset mid-flight: grant 2 reads, assert reset the next cycle -> rd_resp_valid stays 0 through and after reset; first grant after release goes to client 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the scratch-RAM access arbiter.
// Packed client buses hold client i at bits [i*W +: W].
package ram_arb_pkg;

    localparam int RAM_RD_LATENCY = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Width of a client index; a single client still gets a 1-bit ID.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the client after the last one granted gets top priority.
// The pointer only moves when the parent confirms the grant was used.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = id_width(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one 1R/1W scratch RAM between NUM_RD readers and NUM_WR writers and
// returns read data tagged with the requester ID, aligned to the RAM latency.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_ID_W    = id_width(NUM_RD)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_gnt,
    input  logic [NUM_WR-1:0]            wr_req,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]            wr_gnt,
    output logic                         rd_resp_valid,
    output logic [RD_ID_W-1:0]           rd_resp_id,
    output logic [DATA_WIDTH-1:0]        rd_resp_data,
    output logic                         ram_read_req,
    output logic [ADDR_WIDTH-1:0]        ram_read_addr,
    input  logic [DATA_WIDTH-1:0]        ram_read_data,
    output logic                         ram_write_req,
    output logic [ADDR_WIDTH-1:0]        ram_write_addr,
    output logic [DATA_WIDTH-1:0]        ram_write_data
);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic [NUM_RD-1:0]     rd_cand;
    logic [NUM_WR-1:0]     wr_cand;
    logic [ADDR_WIDTH-1:0] rd_cand_addr;
    logic [RD_ID_W-1:0]    rd_cand_id;
    logic [ADDR_WIDTH-1:0] wr_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;
    logic                  hazard;
    logic                  rd_fire;
    logic                  wr_fire;

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clk     (clk),
        .reset   (rst_int_n),
        .req     (rd_req),
        .advance (rd_fire),
        .gnt     (rd_cand)
    );

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clk     (clk),
        .reset   (rst_int_n),
        .req     (wr_req),
        .advance (wr_fire),
        .gnt     (wr_cand)
    );

    always_comb begin
        rd_cand_addr = '0;
        rd_cand_id   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_cand[i]) begin
                rd_cand_addr = rd_cand_addr | rd_addr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
                rd_cand_id   = RD_ID_W'(i);
            end
        end
    end

    always_comb begin
        wr_sel_addr = '0;
        wr_sel_data = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_cand[j]) begin
                wr_sel_addr = wr_sel_addr | wr_addr[slice_lsb(j, ADDR_WIDTH) +: ADDR_WIDTH];
                wr_sel_data = wr_sel_data | wr_data[slice_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    // A same-cycle read of the address being written would see stale data,
    // so the read waits one cycle and its pointer stays put.
    assign hazard  = (|rd_cand) && (|wr_cand) && (rd_cand_addr == wr_sel_addr);
    assign rd_gnt  = hazard ? '0 : rd_cand;
    assign wr_gnt  = wr_cand;
    assign rd_fire = |rd_gnt;
    assign wr_fire = |wr_gnt;

    assign ram_read_req   = rd_fire;
    assign ram_read_addr  = hazard ? '0 : rd_cand_addr;
    assign ram_write_req  = wr_fire;
    assign ram_write_addr = wr_sel_addr;
    assign ram_write_data = wr_sel_data;

    logic [RAM_RD_LATENCY-1:0]              pipe_vld;
    logic [RAM_RD_LATENCY-1:0][RD_ID_W-1:0] pipe_id;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld[0] <= rd_fire;
            pipe_id[0]  <= rd_cand_id;
            for (int k = 1; k < RAM_RD_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
            end
        end
    end

    assign rd_resp_valid = pipe_vld[RAM_RD_LATENCY-1];
    assign rd_resp_id    = pipe_id[RAM_RD_LATENCY-1];
    assign rd_resp_data  = ram_read_data;

endmodule
